// File: rtl/ci_issuer_pkg.sv
// Types and constants shared by the CI issuer, its interface and the CI slaves it drives.
package ci_issuer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP,
      ABORT
   } state_t;

   // Opcode values agreed with the slave op units
   typedef enum logic [7:0] {
      OP_NOP = 8'h00,
      OP_ADD = 8'h01,
      OP_MUL = 8'h02,
      OP_CVT = 8'h08
   } ci_op_t;

endpackage

// File: rtl/ci_issuer_if.sv
// Command, custom-instruction and response signals of the CI issuer; master is the issuer side.
interface ci_issuer_if #(
   parameter int N_W = 8
);

   logic           cmd_valid;
   logic           cmd_ready;
   logic [N_W-1:0] cmd_n;
   logic [31:0]    cmd_dataa;
   logic [31:0]    cmd_datab;

   logic [31:0]    ci_dataa;
   logic [31:0]    ci_datab;
   logic [N_W-1:0] ci_n;
   logic           ci_start;
   logic           ci_clk_en;
   logic           ci_reset;
   logic [31:0]    ci_result;
   logic           ci_done;

   logic           rsp_valid;
   logic           rsp_ready;
   logic [31:0]    rsp_result;
   logic [N_W-1:0] rsp_n;
   logic           rsp_err;

   modport master (
      input  cmd_valid, cmd_n, cmd_dataa, cmd_datab, ci_result, ci_done, rsp_ready,
      output cmd_ready, ci_dataa, ci_datab, ci_n, ci_start, ci_clk_en, ci_reset,
             rsp_valid, rsp_result, rsp_n, rsp_err
   );

   modport slave (
      output cmd_valid, cmd_n, cmd_dataa, cmd_datab, ci_result, ci_done, rsp_ready,
      input  cmd_ready, ci_dataa, ci_datab, ci_n, ci_start, ci_clk_en, ci_reset,
             rsp_valid, rsp_result, rsp_n, rsp_err
   );

endinterface

// File: rtl/ci_issuer.sv
// Issues one Nios II custom-instruction op at a time from a valid/ready command and returns its result.
// Build option CI_TIMEOUT_EN: variable-latency ops abort after TIMEOUT wait cycles (rsp_err=1).
module ci_issuer
   import ci_issuer_pkg::*;
#(
   parameter int N_W       = 8,
   parameter int FIXED_LAT = 0,
   parameter int TIMEOUT   = 256
) (
   input logic         clk,
   input logic         reset_n,
   ci_issuer_if.master bus
);

   // One counter serves both the fixed-latency countdown and the timeout count-up
   localparam int CNT_MAX = (FIXED_LAT > TIMEOUT) ? FIXED_LAT : TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] LAT_LD  = CNT_W'(FIXED_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef CI_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
`endif

   state_t         state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [N_W-1:0] n_q;
   logic [31:0]    a_q, b_q, res_q;
   logic           accept, capture;

   assign accept = bus.cmd_valid && bus.cmd_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      case (state)
         IDLE:  if (accept) state_nx = ISSUE;
         ISSUE: begin
            if (FIXED_LAT == 0 && bus.ci_done) begin
               capture  = 1'b1;
               state_nx = RESP;
            end else begin
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (FIXED_LAT > 0) begin
               if (cnt == CNT_ONE) begin
                  capture  = 1'b1;
                  state_nx = RESP;
               end
            end else if (bus.ci_done) begin
               capture  = 1'b1;
               state_nx = RESP;
            end
`ifdef CI_TIMEOUT_EN
            else if (cnt == TO_LAST) begin
               state_nx = ABORT;
            end
`endif
         end
         RESP:    if (bus.rsp_ready) state_nx = IDLE;
         ABORT:   state_nx = RESP;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_q   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
         cnt   <= '0;
      end else begin
         if (accept) begin
            n_q <= bus.cmd_n;
            a_q <= bus.cmd_dataa;
            b_q <= bus.cmd_datab;
         end
         if (capture) res_q <= bus.ci_result;
`ifdef CI_TIMEOUT_EN
         if (state == ABORT) res_q <= '0;
`endif
         if (state == ISSUE)     cnt <= (FIXED_LAT > 0) ? LAT_LD : '0;
         else if (state == WAIT) cnt <= (FIXED_LAT > 0) ? cnt - CNT_ONE : cnt + CNT_ONE;
      end
   end

`ifdef CI_TIMEOUT_EN
   logic err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)           err_q <= 1'b0;
      else if (capture)       err_q <= 1'b0;
      else if (state == ABORT) err_q <= 1'b1;
   end

   assign bus.rsp_err  = err_q;
   assign bus.ci_reset = !reset_n || (state == ABORT);
`else
   assign bus.rsp_err  = 1'b0;
   assign bus.ci_reset = !reset_n;
`endif

   assign bus.cmd_ready  = reset_n && (state == IDLE);
   assign bus.ci_start   = (state == ISSUE);
   assign bus.ci_clk_en  = (state == ISSUE) || (state == WAIT);
   assign bus.ci_dataa   = a_q;
   assign bus.ci_datab   = b_q;
   assign bus.ci_n       = n_q;
   assign bus.rsp_valid  = (state == RESP);
   assign bus.rsp_result = res_q;
   assign bus.rsp_n      = n_q;

endmodule
